// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_prefetch_queue
// Purpose  : Sequential ibus prefetcher buffering {pc, instr} pairs for decode,
//            with redirect flush and discard of an in-flight response.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_prefetch_queue #(
   parameter int                ADDR_W   = 64,
   parameter int                INSTR_W  = 32,
   parameter int                DEPTH    = 4,
   parameter int                CNT_W    = 16,
   parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(64'h8000_0000)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ADDR_W-1:0]  out_pc,
   output logic [INSTR_W-1:0] out_instr,
   output logic               ibus_req_valid,
   output logic [ADDR_W-1:0]  ibus_req_addr,
   input  logic               ibus_resp_addr_ok,
   input  logic               ibus_resp_data_ok,
   input  logic [INSTR_W-1:0] ibus_resp_data,
   output logic [CNT_W-1:0]   drop_count
);

   localparam int                PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0]    CNT_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
   localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
   localparam logic [CNT_W-1:0]  DROP_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]     count_q, count_d;
   logic [CNT_W-1:0]   drop_count_q, drop_count_d;
   logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
   logic [ADDR_W-1:0]  pc_mem_d    [DEPTH];
   logic [INSTR_W-1:0] instr_mem_q [DEPTH];
   logic [INSTR_W-1:0] instr_mem_d [DEPTH];

   logic               completion;
   logic               push;
   logic               pop;
   logic               credit;
   logic               drop_inc;
   logic [PTR_W:0]     count_nf;
   logic [ADDR_W-1:0]  redir_pc;
   logic               unused_redir_low;

   assign completion       = ibus_req_valid & ibus_resp_addr_ok & ibus_resp_data_ok;
   assign push             = (state_q == S_REQ) & completion & ~redirect_valid;
   assign pop              = out_valid & out_ready;
   assign redir_pc         = {redirect_pc[ADDR_W-1:2], 2'b00};
   assign unused_redir_low = ^redirect_pc[1:0];

   assign out_valid      = (count_q != '0) & ~redirect_valid;
   assign out_pc         = pc_mem_q[rd_ptr_q];
   assign out_instr      = instr_mem_q[rd_ptr_q];
   assign ibus_req_valid = (state_q == S_REQ) | (state_q == S_DROP);
   assign ibus_req_addr  = req_pc_q;
   assign drop_count     = drop_count_q;

   // Occupancy after this cycle's push/pop, ignoring any flush; a new fetch
   // may only be in flight while this leaves room for its response.
   always_comb begin
      count_nf = count_q;
      if (push && !pop) begin
         count_nf = count_q + CNT_ONE;
      end else if (pop && !push) begin
         count_nf = count_q - CNT_ONE;
      end
   end

   assign credit = (count_nf < FULL_CNT);

   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      req_pc_d     = req_pc_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_nf;
      drop_count_d = drop_count_q;
      pc_mem_d     = pc_mem_q;
      instr_mem_d  = instr_mem_q;
      drop_inc     = 1'b0;

      if (push) begin
         pc_mem_d[wr_ptr_q]    = req_pc_q;
         instr_mem_d[wr_ptr_q] = ibus_resp_data;
         wr_ptr_d              = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (redirect_valid) begin
         fetch_pc_d = redir_pc;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end

      case (state_q)
         S_IDLE: begin
            if (!redirect_valid && credit) begin
               state_d  = S_REQ;
               req_pc_d = fetch_pc_q;
            end
         end
         S_REQ: begin
            if (redirect_valid) begin
               // The outstanding fetch cannot be retracted; DROP waits it out.
               drop_inc = completion;
               state_d  = completion ? S_IDLE : S_DROP;
            end else if (completion) begin
               fetch_pc_d = req_pc_q + PC_STEP;
               if (credit) begin
                  req_pc_d = req_pc_q + PC_STEP;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_DROP: begin
            if (completion) begin
               drop_inc = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (drop_inc && (drop_count_q != '1)) begin
         drop_count_d = drop_count_q + DROP_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         fetch_pc_q   <= PC_RESET;
         req_pc_q     <= PC_RESET;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         drop_count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]    <= '0;
            instr_mem_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         req_pc_q     <= req_pc_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         drop_count_q <= drop_count_d;
         pc_mem_q     <= pc_mem_d;
         instr_mem_q  <= instr_mem_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_prefetch_queue
// Purpose  : Scoreboard bench for fetch_prefetch_queue with a simple ibus model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_pc;
   logic [31:0] out_instr;
   logic        ibus_req_valid;
   logic [63:0] ibus_req_addr;
   logic        ibus_resp_addr_ok = 1'b0;
   logic        ibus_resp_data_ok = 1'b0;
   logic [31:0] ibus_resp_data = '0;
   logic [15:0] drop_count;

   logic        bus_en = 1'b0;
   logic        bus_force = 1'b0;
   int          comp_cnt = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   logic [63:0] exp_pc[$];
   logic [63:0] exp_req[$];

   fetch_prefetch_queue dut (
      .clk               (clk),
      .rst               (rst),
      .redirect_valid    (redirect_valid),
      .redirect_pc       (redirect_pc),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_pc            (out_pc),
      .out_instr         (out_instr),
      .ibus_req_valid    (ibus_req_valid),
      .ibus_req_addr     (ibus_req_addr),
      .ibus_resp_addr_ok (ibus_resp_addr_ok),
      .ibus_resp_data_ok (ibus_resp_data_ok),
      .ibus_resp_data    (ibus_resp_data),
      .drop_count        (drop_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [63:0] a);
      return a[31:0] ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Bus model: completes the presented request one cycle after it appears.
   always begin
      @(posedge clk);
      #2;
      if (bus_force || (bus_en && ibus_req_valid)) begin
         ibus_resp_addr_ok = 1'b1;
         ibus_resp_data_ok = 1'b1;
         ibus_resp_data    = instr_of(ibus_req_addr);
      end else begin
         ibus_resp_addr_ok = 1'b0;
         ibus_resp_data_ok = 1'b0;
      end
   end

   // Output monitor: every accepted head is compared with the next expected entry.
   always begin
      @(negedge clk);
      if (out_valid && out_ready) begin
         if (exp_pc.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_pop: got pc %h expected no transfer", out_pc);
         end else begin
            logic [63:0] e;
            e = exp_pc.pop_front();
            check("out_pc", out_pc, e);
            check("out_instr", {32'h0, out_instr}, {32'h0, instr_of(e)});
         end
      end
   end

   // Request monitor: addresses of completed fetches, in order.
   always begin
      @(negedge clk);
      if (ibus_req_valid && ibus_resp_addr_ok && ibus_resp_data_ok) begin
         comp_cnt++;
         if (exp_req.size() != 0) begin
            logic [63:0] e;
            e = exp_req.pop_front();
            check("req_addr", ibus_req_addr, e);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      exp_pc.delete();
      exp_req.delete();
      rst            = 1'b1;
      redirect_valid = 1'b0;
      out_ready      = 1'b0;
      bus_en         = 1'b0;
      bus_force      = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic drain(input string name);
      int cyc = 0;
      while ((exp_pc.size() != 0 || exp_req.size() != 0) && cyc < 300) begin
         @(posedge clk);
         cyc++;
      end
      #1 out_ready = 1'b0;
      check({name, "_drained"}, 64'(exp_pc.size() + exp_req.size()), 64'd0);
   endtask

   task automatic push_seq(input logic [63:0] base, input int n, input bit to_out);
      for (int i = 0; i < n; i++) begin
         exp_req.push_back(base + 64'(4 * i));
         if (to_out) exp_pc.push_back(base + 64'(4 * i));
      end
   endtask

   initial begin
      int cyc;
      int gaps;

      // Streaming: first request right after reset, one instruction per cycle.
      do_reset();
      check("rst_req_valid", {63'h0, ibus_req_valid}, 64'd0);
      check("rst_out_valid", {63'h0, out_valid}, 64'd0);
      check("rst_drop_count", {48'h0, drop_count}, 64'd0);
      bus_en    = 1'b1;
      out_ready = 1'b1;
      push_seq(64'h8000_0000, 8, 1'b1);
      @(posedge clk); #1;
      check("first_req_valid", {63'h0, ibus_req_valid}, 64'd1);
      check("first_req_addr", ibus_req_addr, 64'h8000_0000);
      cyc = 0;
      @(negedge clk);
      while (!out_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      gaps = 0;
      repeat (7) begin
         @(negedge clk);
         if (!out_valid) gaps++;
      end
      check("stream_gaps", 64'(gaps), 64'd0);
      drain("stream");

      // Backpressure: exactly DEPTH completions, then resume in order.
      do_reset();
      bus_en   = 1'b1;
      comp_cnt = 0;
      push_seq(64'h8000_0000, 8, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      check("full_completions", 64'(comp_cnt), 64'd4);
      check("full_req_valid", {63'h0, ibus_req_valid}, 64'd0);
      check("full_out_valid", {63'h0, out_valid}, 64'd1);
      push_seq(64'h8000_0000, 8, 1'b1);
      exp_req.delete();
      push_seq(64'h8000_0010, 4, 1'b0);
      out_ready = 1'b1;
      drain("resume");

      // Redirect while a request is stalled: response dropped, refetch aligned.
      do_reset();
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_1002;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      check("drop_req_held", {63'h0, ibus_req_valid}, 64'd1);
      check("drop_req_addr", ibus_req_addr, 64'h8000_0000);
      check("drop_count_before", {48'h0, drop_count}, 64'd0);
      exp_req.push_back(64'h8000_0000);
      push_seq(64'h8000_1000, 4, 1'b1);
      bus_en = 1'b1;
      drain("redir_stall");
      check("drop_count_stall", {48'h0, drop_count}, 64'd1);

      // Redirect coinciding with a completion and a pop.
      do_reset();
      bus_en    = 1'b1;
      out_ready = 1'b1;
      exp_req.push_back(64'h8000_0000);
      exp_req.push_back(64'h8000_0004);
      exp_req.push_back(64'h8000_0008);
      exp_req.push_back(64'h8000_000C);
      exp_pc.push_back(64'h8000_0000);
      exp_pc.push_back(64'h8000_0004);
      push_seq(64'h8000_2000, 2, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_2000;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      @(negedge clk);
      check("redir_comp_out_valid", {63'h0, out_valid}, 64'd0);
      check("redir_comp_drop", {48'h0, drop_count}, 64'd1);
      drain("redir_comp");

      // Two redirects during one DROP: only the last target is fetched.
      do_reset();
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_3000;
      @(posedge clk); #1;
      redirect_pc    = 64'h8000_4000;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      exp_req.push_back(64'h8000_0000);
      push_seq(64'h8000_4000, 2, 1'b1);
      bus_en = 1'b1;
      drain("double_redir");
      check("double_redir_drop", {48'h0, drop_count}, 64'd1);

      // Reset mid-fetch with a late completion, then wrap at top of memory.
      do_reset();
      repeat (3) @(posedge clk);
      #1;
      check("pre_rst_outstanding", {63'h0, ibus_req_valid}, 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst       = 1'b0;
      bus_force = 1'b1;
      check("rst_mid_req_valid", {63'h0, ibus_req_valid}, 64'd0);
      @(posedge clk); #1;
      bus_force = 1'b0;
      @(posedge clk); #1;
      check("late_resp_out_valid", {63'h0, out_valid}, 64'd0);
      check("restart_addr", ibus_req_addr, 64'h8000_0000);
      check("late_resp_drop", {48'h0, drop_count}, 64'd0);
      redirect_valid = 1'b1;
      redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
      out_ready      = 1'b1;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      exp_req.push_back(64'h8000_0000);
      exp_req.push_back(64'hFFFF_FFFF_FFFF_FFFC);
      exp_req.push_back(64'h0);
      exp_req.push_back(64'h4);
      exp_pc.push_back(64'hFFFF_FFFF_FFFF_FFFC);
      exp_pc.push_back(64'h0);
      exp_pc.push_back(64'h4);
      bus_en = 1'b1;
      drain("wrap");
      check("wrap_drop", {48'h0, drop_count}, 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
